// File: rtl/checkpoint_pkg.sv
// Shared types and default marker codes for the checkpoint monitor and its expected-value FIFO.
// Firmware drives these markers on the GPIO probe field to frame a test run.
package checkpoint_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle  = 3'd0,
        StArmed = 3'd1,
        StRun   = 3'd2,
        StPass  = 3'd3,
        StFail  = 3'd4,
        StTmo   = 3'd5
    } state_e;

    localparam logic [15:0] DEF_START_CODE = 16'hAB40;
    localparam logic [15:0] DEF_PASS_CODE  = 16'hAB51;
    localparam logic [15:0] DEF_FAIL_CODE  = 16'hAB5F;

    function automatic logic is_terminal(input state_e s);
        return (s == StPass) || (s == StFail) || (s == StTmo);
    endfunction

endpackage

// File: rtl/checkpoint_fifo.sv
// Synchronous FIFO holding the expected checkpoint values, with a synchronous clear.
// A push offered while full is taken only when a pop happens in the same cycle.
module checkpoint_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_clr,
    input  logic                         i_push,
    input  logic [DATA_W-1:0]            i_data,
    input  logic                         i_pop,
    output logic [DATA_W-1:0]            o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/checkpoint_monitor.sv
// Synchronises and debounces the firmware probe field, reports each stable change and
// tracks the START / PASS / FAIL protocol against a queue of expected checkpoints.
module checkpoint_monitor
    import checkpoint_pkg::*;
#(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       STABLE_CYC  = 4,
    parameter logic [DATA_W-1:0] START_CODE  = DATA_W'(DEF_START_CODE),
    parameter logic [DATA_W-1:0] PASS_CODE   = DATA_W'(DEF_PASS_CODE),
    parameter logic [DATA_W-1:0] FAIL_CODE   = DATA_W'(DEF_FAIL_CODE),
    parameter int unsigned       TIMEOUT_CYC = 250000,
    parameter int unsigned       EXP_DEPTH   = 8,
    parameter int unsigned       IDX_W       = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [DATA_W-1:0]  probe_i,
    input  logic               enable_i,
    input  logic               exp_valid_i,
    input  logic [DATA_W-1:0]  exp_data_i,
    output logic               exp_ready_o,
    output logic               change_valid_o,
    output logic [DATA_W-1:0]  change_data_o,
    output logic [IDX_W-1:0]   change_idx_o,
    output logic [STATE_W-1:0] state_o,
    output logic               pass_o,
    output logic               fail_o,
    output logic               timeout_o,
    output logic               mismatch_o,
    output logic               done_o
);

    localparam int unsigned DB_W  = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CNT_W = $clog2(EXP_DEPTH) + 1;
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(STABLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [DATA_W-1:0] r_sync1;
    logic [DATA_W-1:0] r_sync2;
    logic [DATA_W-1:0] r_cand;
    logic [DATA_W-1:0] r_last;
    logic [DB_W-1:0]   r_db_cnt;
    logic              w_accept;

    logic              r_chg_valid;
    logic [DATA_W-1:0] r_chg_data;
    logic [IDX_W-1:0]  r_chg_idx;

    state_e            r_state;
    state_e            w_state_next;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              w_tmo_hit;
    logic              r_mismatch;
    logic              w_mismatch_set;
    logic              w_is_marker;
    logic              w_pop;

    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;

    // Candidate restarts on any difference; acceptance needs STABLE_CYC matching samples.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cand   <= '0;
            r_db_cnt <= '0;
            r_last   <= '0;
        end else begin
            r_sync1 <= probe_i;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand   <= r_sync2;
                r_db_cnt <= '0;
            end else if (r_db_cnt != DB_MAX) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (w_accept) begin
                r_last <= r_cand;
            end
        end
    end

    assign w_accept = (r_db_cnt == DB_MAX) && (r_cand != r_last);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_chg_valid <= 1'b0;
            r_chg_data  <= '0;
            r_chg_idx   <= '0;
        end else begin
            r_chg_valid <= w_accept;
            if (w_accept) begin
                r_chg_data <= r_cand;
                r_chg_idx  <= r_chg_idx + 1'b1;
            end
        end
    end

    assign change_valid_o = r_chg_valid;
    assign change_data_o  = r_chg_data;
    assign change_idx_o   = r_chg_idx;

    checkpoint_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (EXP_DEPTH)
    ) u_exp_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_clr   (~enable_i),
        .i_push  (exp_valid_i),
        .i_data  (exp_data_i),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign exp_ready_o = ~w_full;

    assign w_tmo_hit   = ((r_state == StArmed) || (r_state == StRun)) && (r_tmo_cnt == TMO_LAST);
    assign w_is_marker = (r_cand == START_CODE) || (r_cand == PASS_CODE) || (r_cand == FAIL_CODE);
    assign w_pop       = enable_i && (r_state == StRun) && w_accept && !w_tmo_hit
                         && !w_is_marker && !w_empty;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || r_state == StIdle) begin
            r_tmo_cnt <= '0;
        end else if (((r_state == StArmed) || (r_state == StRun)) && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_mismatch_set = 1'b0;
        if (!enable_i) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    w_state_next = StArmed;
                end
                StArmed: begin
                    if (w_tmo_hit) begin
                        w_state_next = StTmo;
                    end else if (w_accept && (r_cand == START_CODE)) begin
                        w_state_next = StRun;
                    end
                end
                StRun: begin
                    if (w_tmo_hit) begin
                        w_state_next = StTmo;
                    end else if (w_accept) begin
                        if (r_cand == PASS_CODE) begin
                            // Outstanding expected checkpoints at PASS mean some were skipped.
                            if (w_count == '0) begin
                                w_state_next = StPass;
                            end else begin
                                w_state_next   = StFail;
                                w_mismatch_set = 1'b1;
                            end
                        end else if (r_cand == FAIL_CODE) begin
                            w_state_next = StFail;
                        end else if ((r_cand != START_CODE) && !w_empty && (w_head != r_cand)) begin
                            w_state_next   = StFail;
                            w_mismatch_set = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !enable_i) begin
            r_mismatch <= 1'b0;
        end else if (w_mismatch_set) begin
            r_mismatch <= 1'b1;
        end
    end

    // Terminal states are left only via enable_i=0, which also clears status, so these stay sticky.
    always_comb begin
        pass_o     = (r_state == StPass);
        fail_o     = (r_state == StFail);
        timeout_o  = (r_state == StTmo);
        done_o     = is_terminal(r_state);
        mismatch_o = r_mismatch;
        state_o    = r_state;
    end

endmodule

// File: doc/checkpoint_monitor.md
Name: checkpoint_monitor

Overview:
Synthesizable, parametrised checkpoint monitor for the user-project GPIO field that firmware drives with progress and status codes.
- Synchronises and debounces a DATA_W-bit probe bus.
- Reports every stable value change.
- Tracks the START / PASS / FAIL protocol and compares checkpoints against an expected-value queue.
- Flags a global timeout.
It replaces ad-hoc bench monitors and sits beside the user project, feeding LA/status registers.

Parameters:
DATA_W, 16, probe field width
STABLE_CYC, 4, cycles a synchronised value must hold before acceptance (>=1)
START_CODE, 16'hAB40, start marker (DATA_W bits)
PASS_CODE, 16'hAB51, pass marker
FAIL_CODE, 16'hAB5F, firmware-declared fail marker
TIMEOUT_CYC, 250000, cycles allowed from arming to terminal state
EXP_DEPTH, 8, expected-checkpoint FIFO depth (power of 2)
IDX_W, 8, change-counter width

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous active-high reset
probe_i  in  DATA_W  asynchronous probe field (e.g. mprj_io[31:16])
enable_i  in  1  arm monitor; deassert returns to IDLE
exp_valid_i  in  1  push expected checkpoint
exp_data_i  in  DATA_W  expected value
exp_ready_o  out  1  FIFO not full
change_valid_o  out  1  one-cycle pulse per accepted change
change_data_o  out  DATA_W  accepted value
change_idx_o  out  IDX_W  running change count (wraps)
state_o  out  3  FSM state encoding
pass_o / fail_o / timeout_o / mismatch_o  out  1 each  sticky status
done_o  out  1  in terminal state

Behaviour:
- Reset: all outputs 0, except exp_ready_o=1. Last-accepted value=0, FIFO empty, counters 0, state IDLE.
- Sync: 2-flop synchroniser per bit. A debounce candidate register restarts its counter whenever the synchronised value differs. When the value has held STABLE_CYC cycles and differs from the last accepted value, it is accepted.
- Latency: a clean step on probe_i at edge t gives change_valid_o high on edge t+2+STABLE_CYC. change_data_o and change_idx_o (post-increment) are valid with the pulse. Glitches shorter than STABLE_CYC produce nothing.
- Returning to a previous value counts as a change. change_idx_o wraps 2^IDX_W-1 -> 0.
- States: IDLE(0), ARMED(1), RUN(2), PASS(3), FAIL(4), TMO(5).
  - IDLE -> ARMED when enable_i=1. Timeout counter clears on entry to ARMED.
  - ARMED: changes are reported but not compared. START_CODE -> RUN.
  - RUN: on each accepted change:
    - PASS_CODE with FIFO empty -> PASS.
    - PASS_CODE with FIFO non-empty -> FAIL, mismatch_o=1 (missing checkpoints).
    - FAIL_CODE -> FAIL.
    - START_CODE: ignored, no compare.
    - Any other value: pop FIFO head and compare. Mismatch -> FAIL, mismatch_o=1. FIFO empty -> accept unchecked.
  - ARMED/RUN: counter reaching TIMEOUT_CYC-1 -> TMO, timeout_o=1. Timeout takes priority over a same-cycle accepted change.
  - Terminal states hold and set done_o. Status bits are sticky.
  - enable_i=0 from any state -> IDLE next cycle. Status bits and FIFO clear. Change reporting continues in all states.
- FIFO: push when exp_valid_i & exp_ready_o. Push and pop in the same cycle are legal even when full. Push while full is dropped.
- wb_rst_i mid-operation: everything returns to reset values on the next edge; the synchroniser is flushed.

Decomposition:
- Package checkpoint_pkg: state enum (IDLE..TMO), default marker constants, state_o width.
- One sub-module, checkpoint_fifo: synchronous FIFO, DATA_W x EXP_DEPTH, full/empty/count, same-cycle push+pop.
- Synchroniser and debounce stay inline.

Test Plan:
- Reset, then probe 0x0000 -> 0x1234 with STABLE_CYC=4 -> change_valid_o exactly 6 cycles after the step, change_data_o=0x1234, change_idx_o=1.
- 2-cycle glitch 0x0000->0x00FF->0x0000 -> no change_valid_o, change_idx_o unchanged.
- Enable; push 40, 893, 2541, 2669; drive AB40, 40, 893, 2541, 2669, AB51 -> state RUN then PASS, pass_o=1, done_o=1, FIFO empty.
- Same sequence with 894 in place of 893 -> FAIL on that change, mismatch_o=1, fail_o=1. Later changes are still reported but the state holds.
- Enable with no START and TIMEOUT_CYC=1000 -> timeout_o=1 at cycle 1000 after arming. A change accepted on that same cycle still yields TMO.
- Fill FIFO to 8 -> exp_ready_o=0; push+pop in the same cycle keeps count=8. Assert wb_rst_i mid-RUN -> all outputs at reset values the next cycle.
